// File: rtl/reg_file_2r1w.sv
// Two-read, one-write architectural register file. Register 0 reads as zero;
// an optional write-through path forwards a same-cycle write to the read ports.
module reg_file_2r1w #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int WRITE_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  // Writes to address 0 are dropped so regs[0] stays at its reset value of zero.
  always_comb begin
    wr_en = we3 && (wa3 != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa3] <= wd3;
    end
  end

  // Forwarding is gated by rst_n so a pending write cannot leak out during reset.
  always_comb begin
    byp1 = (WRITE_BYPASS != 0) && rst_n && wr_en && (wa3 == ra1);
    byp2 = (WRITE_BYPASS != 0) && rst_n && wr_en && (wa3 == ra2);
  end

  always_comb begin
    rd1 = '0;
    if (rst_n && (ra1 != '0)) begin
      rd1 = byp1 ? wd3 : regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (rst_n && (ra2 != '0)) begin
      rd2 = byp2 ? wd3 : regs[ra2];
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed vectors plus a random sequence, checked against
// a transaction-level register model for both the bypass and non-bypass builds.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        we3 = 1'b0;
  logic [4:0]  wa3 = '0;
  logic [31:0] wd3 = '0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mem [32];

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .WRITE_BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .WRITE_BYPASS(0)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  // Expected read value straight from the behavioural rules.
  function automatic logic [31:0] expect_rd(input logic [4:0] ra, input bit byp);
    if (!rst_n || ra == 0) return '0;
    if (byp && we3 && wa3 == ra) return wd3;
    return mem[ra];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    we3 = we; wa3 = wa; wd3 = wd; ra1 = a1; ra2 = a2;
  endtask

  task automatic edge_tick();
    @(posedge clk);
    if (rst_n && we3 && wa3 != 0) mem[wa3] = wd3;
  endtask

  // Continuous compare against the model, well away from both clock edges.
  always @(negedge clk) begin
    #3;
    check("rd1_byp", rd1_b, expect_rd(ra1, 1'b1));
    check("rd2_byp", rd2_b, expect_rd(ra2, 1'b1));
    check("rd1_nobyp", rd1_n, expect_rd(ra1, 1'b0));
    check("rd2_nobyp", rd2_n, expect_rd(ra2, 1'b0));
  end

  int rst_hold;

  initial begin
    clear_model();
    #1 rst_n = 1'b0;
    repeat (2) edge_tick();

    // Reset state, then release.
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #2 check("reset_rd1", rd1_b, 32'h0);
    check("reset_rd2", rd2_b, 32'h0);
    rst_n = 1'b1;
    edge_tick();

    // Basic write then read.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    edge_tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    #2 check("wr5_rd1", rd1_b, 32'hDEADBEEF);
    check("wr5_rd2", rd2_b, 32'h0);
    check("wr5_rd1_nobyp", rd1_n, 32'hDEADBEEF);
    edge_tick();

    // Register 0 is immutable, bypass included.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #2 check("r0_byp_blocked", rd1_b, 32'h0);
    edge_tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2 check("r0_after_edge", rd1_b, 32'h0);
    check("r0_after_edge_nobyp", rd1_n, 32'h0);
    edge_tick();

    // Same-cycle write to both read addresses.
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    #2 check("byp_rd1", rd1_b, 32'h12345678);
    check("byp_rd2", rd2_b, 32'h12345678);
    check("nobyp_old_rd1", rd1_n, 32'h0);
    check("nobyp_old_rd2", rd2_n, 32'h0);
    edge_tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    #2 check("nobyp_new_rd1", rd1_n, 32'h12345678);
    check("nobyp_new_rd2", rd2_n, 32'h12345678);
    edge_tick();

    // Reset held across an edge suppresses the write.
    drive(1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    rst_n = 1'b0;
    clear_model();
    #2 check("rst_byp_blocked", rd1_b, 32'h0);
    edge_tick();
    drive(1'b0, 5'd3, 32'h1, 5'd3, 5'd3);
    rst_n = 1'b1;
    #2 check("rst_no_write_rd1", rd1_b, 32'h0);
    check("rst_no_write_nobyp", rd1_n, 32'h0);
    edge_tick();
    drive(1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
    edge_tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #2 check("post_rst_write", rd1_b, 32'h1);
    check("post_rst_write_nobyp", rd1_n, 32'h1);
    edge_tick();

    // Asynchronous reset mid-simulation, landing mid-cycle during a write.
    drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd0);
    edge_tick();
    drive(1'b1, 5'd9, 32'h5A5A5A5A, 5'd9, 5'd5);
    #1 check("pre_reset_rd1", rd1_b, 32'h5A5A5A5A);
    rst_n = 1'b0;
    clear_model();
    #1 check("async_reset_rd1", rd1_b, 32'h0);
    check("async_reset_rd2", rd2_b, 32'h0);
    check("async_reset_nobyp", rd2_n, 32'h0);
    edge_tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'hCAFE0000 | 32'(i), 5'(i), 5'(31 - i));
      edge_tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    rst_n = 1'b1;
    #2 check("after_reset_r9", rd1_b, 32'h0);
    check("after_reset_r5", rd2_b, 32'h0);
    edge_tick();

    // Random traffic with occasional asynchronous reset pulses.
    rst_hold = 0;
    for (int n = 0; n < 10000; n++) begin
      logic [4:0] wa, a1, a2;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 4) == 0) ? a1 : 5'($urandom);
      drive(1'($urandom), wa, $urandom, a1, a2);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        clear_model();
        rst_hold = $urandom_range(1, 3);
      end
      edge_tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    edge_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
